// File: rtl/led_sink_pkg.sv
// Shared constants and types for the LED sink (serial grayscale/dot-correction receiver).
package led_sink_pkg;

    localparam int unsigned CHANNELS      = 16;
    localparam int unsigned GS_BITS       = 12;
    localparam int unsigned DC_BITS       = 6;
    localparam int unsigned GS_FRAME_BITS = 192;
    localparam int unsigned DC_FRAME_BITS = 96;

    // Bit positions of the asynchronous inputs inside the synchronizer bank.
    localparam int SYNC_SCLK  = 0;
    localparam int SYNC_SIN   = 1;
    localparam int SYNC_MODE  = 2;
    localparam int SYNC_XLAT  = 3;
    localparam int SYNC_BLANK = 4;
    localparam int SYNC_GSCLK = 5;
    localparam int NUM_SYNC   = 6;

    typedef logic [GS_BITS-1:0] gs_word_t;
    typedef logic [DC_BITS-1:0] dc_word_t;

endpackage

// File: rtl/led_sink_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse; level and pulse are
// delayed equally so data inputs stay aligned with strobes.
module led_sink_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta_q, sync_q, level_q, rise_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            level_q <= sync_q;
            rise_q  <= sync_q & ~level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/led_sink.sv
// LED driver sink: serial frame capture, grayscale/dot-correction latches and PWM.
// Define LED_SINK_SOUT_EN to add the registered daisy-chain output led_sout.
module led_sink #(
    parameter int unsigned CHANNELS = led_sink_pkg::CHANNELS,
    parameter int unsigned GS_BITS  = led_sink_pkg::GS_BITS,
    parameter int unsigned DC_BITS  = led_sink_pkg::DC_BITS
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        led_sclk,
    input  logic                        led_sin,
    input  logic                        led_mode,
    input  logic                        led_xlat,
    input  logic                        led_blank,
    input  logic                        led_gsclk,
`ifdef LED_SINK_SOUT_EN
    output logic                        led_sout,
`endif
    output logic                        led_xerr,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [CHANNELS*DC_BITS-1:0] dc_value,
    output logic [GS_BITS-1:0]          gs_count
);

    localparam int unsigned GS_FRAME = CHANNELS * GS_BITS;
    localparam int unsigned DC_FRAME = CHANNELS * DC_BITS;
    localparam logic [7:0]  CNT_MAX      = 8'hFF;
    localparam logic [7:0]  GS_FRAME_CNT = 8'(GS_FRAME);
    localparam logic [7:0]  DC_FRAME_CNT = 8'(DC_FRAME);
    localparam logic [GS_BITS-1:0] GS_MAX = '1;

    logic [led_sink_pkg::NUM_SYNC-1:0] async_in, sync_level, sync_rise;

    assign async_in = {led_gsclk, led_blank, led_xlat, led_mode, led_sin, led_sclk};

    for (genvar g = 0; g < led_sink_pkg::NUM_SYNC; g++) begin : g_sync
        led_sink_sync u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .din     (async_in[g]),
            .level   (sync_level[g]),
            .rise    (sync_rise[g])
        );
    end

    logic sclk_rise, xlat_rise, gsclk_rise, sin_lvl, mode_lvl, blank_lvl;

    assign sclk_rise  = sync_rise[led_sink_pkg::SYNC_SCLK];
    assign xlat_rise  = sync_rise[led_sink_pkg::SYNC_XLAT];
    assign gsclk_rise = sync_rise[led_sink_pkg::SYNC_GSCLK];
    assign sin_lvl    = sync_level[led_sink_pkg::SYNC_SIN];
    assign mode_lvl   = sync_level[led_sink_pkg::SYNC_MODE];
    assign blank_lvl  = sync_level[led_sink_pkg::SYNC_BLANK];

    // Edge pulses of data-like inputs and levels of strobe-like inputs are never needed.
    logic unused_sync;
    assign unused_sync = ^{sync_rise[led_sink_pkg::SYNC_SIN], sync_rise[led_sink_pkg::SYNC_MODE],
                           sync_rise[led_sink_pkg::SYNC_BLANK], sync_level[led_sink_pkg::SYNC_SCLK],
                           sync_level[led_sink_pkg::SYNC_XLAT], sync_level[led_sink_pkg::SYNC_GSCLK]};

    logic [GS_FRAME-1:0] shift_q, shift_d;
    logic [GS_FRAME-1:0] gs_latch_q, gs_latch_d;
    logic [DC_FRAME-1:0] dc_q, dc_d;
    logic [7:0]          bit_cnt_q, bit_cnt_d;
    logic [GS_BITS-1:0]  gs_cnt_q, gs_cnt_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                xerr_q, xerr_d;

    always_comb begin
        shift_d    = shift_q;
        gs_latch_d = gs_latch_q;
        dc_d       = dc_q;
        bit_cnt_d  = bit_cnt_q;
        xerr_d     = xerr_q;
        gs_cnt_d   = gs_cnt_q;
        pwm_d      = '0;

        if (sclk_rise) begin
            shift_d = {shift_q[GS_FRAME-2:0], sin_lvl};
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 8'd1;
            end
        end

        // Latches read the pre-shift register, so a coincident sclk edge lands in the next frame.
        if (xlat_rise) begin
            if (mode_lvl) begin
                dc_d   = shift_q[DC_FRAME-1:0];
                xerr_d = (bit_cnt_q == DC_FRAME_CNT);
            end else begin
                gs_latch_d = shift_q;
                xerr_d     = (bit_cnt_q == GS_FRAME_CNT);
            end
            bit_cnt_d = {7'd0, sclk_rise};
        end

        if (blank_lvl) begin
            gs_cnt_d = '0;
        end else if (gsclk_rise && (gs_cnt_q != GS_MAX)) begin
            gs_cnt_d = gs_cnt_q + GS_BITS'(1);
        end

        for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_d[i] = !blank_lvl && (gs_cnt_q < gs_latch_q[i*GS_BITS +: GS_BITS]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            gs_latch_q <= '0;
            dc_q       <= '0;
            bit_cnt_q  <= '0;
            xerr_q     <= 1'b1;
            gs_cnt_q   <= '0;
            pwm_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            gs_latch_q <= gs_latch_d;
            dc_q       <= dc_d;
            bit_cnt_q  <= bit_cnt_d;
            xerr_q     <= xerr_d;
            gs_cnt_q   <= gs_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

`ifdef LED_SINK_SOUT_EN
    logic sout_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sout_q <= 1'b0;
        end else begin
            sout_q <= mode_lvl ? shift_q[DC_FRAME-1] : shift_q[GS_FRAME-1];
        end
    end

    assign led_sout = sout_q;
`endif

    assign led_xerr = xerr_q;
    assign pwm_out  = pwm_q;
    assign dc_value = dc_q;
    assign gs_count = gs_cnt_q;

endmodule

// File: doc/led_sink.md
LED_SINK -- requirements
Module: led_sink

Interface
REQ-001 Parameter CHANNELS, default 16, number of output channels.
REQ-002 Parameter GS_BITS, default 12, grayscale bits per channel.
REQ-003 Parameter DC_BITS, default 6, dot-correction bits per channel.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 led_sclk  input  1  serial shift clock from the driver; asynchronous to clock.
REQ-007 led_sin  input  1  serial data, MSB first.
REQ-008 led_mode  input  1  0 = grayscale frame, 1 = dot-correction frame.
REQ-009 led_xlat  input  1  latch strobe.
REQ-010 led_blank  input  1  1 = all outputs off, grayscale counter cleared.
REQ-011 led_gsclk  input  1  grayscale PWM clock.
REQ-012 led_xerr  output  1  active-low frame-error flag.
REQ-013 pwm_out  output  CHANNELS  per-channel PWM state.
REQ-014 dc_value  output  CHANNELS*DC_BITS  latched dot-correction values; channel 0 in the LSBs.
REQ-015 gs_count  output  GS_BITS  current grayscale counter.

Function
REQ-016 The block SHALL pass led_sclk, led_sin, led_mode, led_xlat, led_blank and led_gsclk through identical 2-flop synchronizers, then detect rising edges one cycle later; all actions SHALL occur 3 clock cycles after the input edge.
REQ-017 The block SHALL shift the synchronized led_sin into a CHANNELS*GS_BITS shift register (192 bits) on each sclk rise, with the new bit entering at bit 0.
REQ-018 The block SHALL increment an 8-bit bit counter on each sclk rise, saturating at 255.
REQ-019 On xlat rise with mode=0, the block SHALL copy the full shift register to the grayscale latch; channel i SHALL take bits [i*12+11:i*12].
REQ-020 On xlat rise with mode=1, the block SHALL copy shift register bits [95:0] to dc_value.
REQ-021 On xlat rise, the block SHALL drive led_xerr low if the bit count is not equal to 192 (mode=0) or 96 (mode=1), and high otherwise; led_xerr SHALL hold that value until the next xlat rise.
REQ-022 Each xlat rise SHALL clear the bit counter to 0.
REQ-023 If sclk and xlat rise in the same cycle, the latch SHALL take the pre-shift register contents, the shift SHALL still occur, and the bit counter SHALL become 1.
REQ-024 On gsclk rise while blank is low, gs_count SHALL increment, saturating at 4095.
REQ-025 While blank is high, gs_count SHALL be held at 0; if blank and gsclk rise in the same cycle, blank SHALL win.
REQ-026 pwm_out[i] SHALL be registered, equal to (!blank && gs_count < gs_latch[i]), with 1 cycle of latency from the gs_count update.
REQ-027 A grayscale value of 0 SHALL keep the channel always off; 4095 SHALL turn the channel off only at saturation.

Reset
REQ-028 While reset_n is low, the block SHALL hold every output at its reset value: pwm_out=0, led_xerr=1, gs_count=0, dc_value=0; the shift register, grayscale latch, bit counter and synchronizers SHALL also be 0.
REQ-029 Reset asserted mid-frame SHALL discard all shifted bits; the first xlat after reset SHALL flag an error unless a full frame was shifted after reset.

Configuration
REQ-030 With LED_SINK_SOUT_EN defined, the block SHALL add an output port led_sout (1 bit) that carries shift register bit 191 (bit 95 when mode=1), registered, for daisy-chaining.
REQ-031 Without LED_SINK_SOUT_EN, the block SHALL have no led_sout port and no associated logic.

Structure
REQ-032 Package led_sink_pkg SHALL hold CHANNELS, GS_BITS, DC_BITS, GS_FRAME_BITS=192, DC_FRAME_BITS=96, and the gs_word_t/dc_word_t typedefs.
REQ-033 A sub-module led_sink_sync (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once per asynchronous input.

Verification
REQ-034 Shift 192 bits (ch0=12'h800, all others 0), mode=0, pulse xlat, blank low, 4096 gsclk -> pwm_out[0] high for exactly 2048 gsclk periods; led_xerr=1.
REQ-035 Shift 191 bits, then xlat -> led_xerr=0; then a correct 192-bit frame plus xlat -> led_xerr=1.
REQ-036 mode=1, shift 96 bits of 6'h2A per channel, xlat -> dc_value = {16{6'h2A}}; grayscale latch unchanged.
REQ-037 Raise blank mid-PWM at gs_count=100 -> gs_count=0 and pwm_out=0 within 4 cycles; simultaneous gsclk pulse ignored.
REQ-038 Assert reset_n low after 50 shifted bits, release, shift 192 bits, xlat -> led_xerr=1 and latch holds only post-reset data.
REQ-039 sclk and xlat rising in the same clock cycle -> latch gets the pre-shift contents and the next xlat with 191 further bits reports led_xerr=1.
